// File: rtl/lsb_queue.sv
// Load/store queue: holds memory ops in program order, captures operands from the CDB,
// issues RAM loads speculatively and holds stores / IO loads until the ROB commits them.
module lsb_queue #(
    parameter int          DEPTH_BIT = 4,
    parameter int          ROB_BIT   = 5,
    parameter int          CDB_NUM   = 2,
    parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear_flag,
    input  logic                       ins_valid,
    input  logic [3:0]                 ins_type,
    input  logic [ROB_BIT-1:0]         ins_rob_id,
    input  logic [31:0]                ins_v1,
    input  logic [31:0]                ins_v2,
    input  logic                       ins_q1_busy,
    input  logic                       ins_q2_busy,
    input  logic [ROB_BIT-1:0]         ins_q1,
    input  logic [ROB_BIT-1:0]         ins_q2,
    input  logic [31:0]                ins_imm,
    output logic                       lsb_full,
    input  logic [CDB_NUM-1:0]         cdb_valid,
    input  logic [CDB_NUM*ROB_BIT-1:0] cdb_rob_id,
    input  logic [CDB_NUM*32-1:0]      cdb_val,
    input  logic                       commit_valid,
    input  logic [ROB_BIT-1:0]         commit_rob_id,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_we,
    output logic [1:0]                 mem_size,
    input  logic                       mem_done,
    input  logic [31:0]                mem_rdata,
    output logic                       out_valid,
    output logic [ROB_BIT-1:0]         out_rob_id,
    output logic [31:0]                out_val
);
    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] C_DEPTH = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT:0] C_FULL  = (DEPTH_BIT+1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    logic [DEPTH-1:0]   r_valid, r_q1_busy, r_q2_busy, r_committed;
    logic [3:0]         r_type [DEPTH];
    logic [ROB_BIT-1:0] r_rob  [DEPTH];
    logic [ROB_BIT-1:0] r_q1   [DEPTH];
    logic [ROB_BIT-1:0] r_q2   [DEPTH];
    logic [31:0]        r_v1   [DEPTH];
    logic [31:0]        r_v2   [DEPTH];
    logic [31:0]        r_imm  [DEPTH];

    logic [DEPTH_BIT-1:0] r_head, r_tail;
    logic [DEPTH_BIT:0]   r_count;
    state_t               r_state, w_state_next;

    logic               r_mem_req, r_mem_we, r_squash;
    logic [31:0]        r_mem_addr, r_mem_wdata;
    logic [1:0]         r_mem_size;
    logic [3:0]         r_cur_type;
    logic [ROB_BIT-1:0] r_cur_rob;
    logic               r_out_valid;
    logic [ROB_BIT-1:0] r_out_rob_id;
    logic [31:0]        r_out_val;

    // Returns {busy, value}; lower CDB ports override higher ones, which override the out port.
    function automatic logic [32:0] f_wake(input logic busy, input logic [ROB_BIT-1:0] q,
                                           input logic [31:0] v);
        logic [32:0] res;
        res = {busy, v};
        if (busy) begin
            if (r_out_valid && r_out_rob_id == q)
                res = {1'b0, r_out_val};
            for (int k = CDB_NUM - 1; k >= 0; k--)
                if (cdb_valid[k] && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == q)
                    res = {1'b0, cdb_val[k*32 +: 32]};
        end
        return res;
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] d, input logic [3:0] t);
        case (t)
            4'd0:    f_ext = {{24{d[7]}}, d[7:0]};
            4'd1:    f_ext = {{16{d[15]}}, d[15:0]};
            4'd4:    f_ext = {24'h0, d[7:0]};
            4'd5:    f_ext = {16'h0, d[15:0]};
            default: f_ext = d;
        endcase
    endfunction

    logic [32:0] w_wake1 [DEPTH];
    logic [32:0] w_wake2 [DEPTH];
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        assign w_wake1[gi] = f_wake(r_q1_busy[gi], r_q1[gi], r_v1[gi]);
        assign w_wake2[gi] = f_wake(r_q2_busy[gi], r_q2[gi], r_v2[gi]);
    end

    logic [32:0] w_ins1, w_ins2;
    assign w_ins1 = f_wake(ins_q1_busy, ins_q1, ins_v1);
    assign w_ins2 = f_wake(ins_q2_busy, ins_q2, ins_v2);

    logic        w_dispatch, w_issue, w_finish, w_report;
    logic        w_head_ready, w_head_store, w_head_io, w_head_commit, w_can_issue;
    logic [31:0] w_head_addr;

    assign w_dispatch    = ins_valid && (r_count != C_DEPTH) && !clear_flag;
    assign w_head_addr   = r_v1[r_head] + r_imm[r_head];
    assign w_head_ready  = r_valid[r_head] && !r_q1_busy[r_head] && !r_q2_busy[r_head];
    assign w_head_store  = r_type[r_head][3];
    assign w_head_io     = !w_head_store && (w_head_addr >= IO_BASE);
    assign w_head_commit = r_committed[r_head] || (commit_valid && commit_rob_id == r_rob[r_head]);
    assign w_can_issue   = w_head_ready && ((!w_head_store && !w_head_io) || w_head_commit);
    assign lsb_full      = r_count >= C_FULL;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else if (rdy_in)
            r_state <= w_state_next;
    end

    // A flushed store stays in BUSY (its result is squashed); a flushed load drains.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!clear_flag && w_can_issue) w_state_next = S_BUSY;
            S_BUSY:  if (mem_done) w_state_next = S_IDLE;
                     else if (clear_flag && !r_mem_we) w_state_next = S_DRAIN;
            S_DRAIN: if (mem_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = (r_state == S_IDLE) && !clear_flag && w_can_issue;
        w_finish = (r_state != S_IDLE) && mem_done;
        w_report = (r_state == S_BUSY) && mem_done && !clear_flag && !r_squash;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (clear_flag) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_dispatch) r_tail <= r_tail + DEPTH_BIT'(1);
                if (w_issue)    r_head <= r_head + DEPTH_BIT'(1);
                r_count <= r_count + (DEPTH_BIT+1)'(w_dispatch) - (DEPTH_BIT+1)'(w_issue);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid     <= '0;
            r_q1_busy   <= '0;
            r_q2_busy   <= '0;
            r_committed <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i] <= '0;
                r_rob[i]  <= '0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_imm[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear_flag) begin
                r_valid <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_dispatch && r_tail == DEPTH_BIT'(i)) begin
                        r_valid[i]                <= 1'b1;
                        r_type[i]                 <= ins_type;
                        r_rob[i]                  <= ins_rob_id;
                        r_q1[i]                   <= ins_q1;
                        r_q2[i]                   <= ins_q2;
                        r_imm[i]                  <= ins_imm;
                        {r_q1_busy[i], r_v1[i]}   <= w_ins1;
                        {r_q2_busy[i], r_v2[i]}   <= w_ins2;
                        r_committed[i]            <= commit_valid && commit_rob_id == ins_rob_id;
                    end else begin
                        if (w_issue && r_head == DEPTH_BIT'(i))
                            r_valid[i] <= 1'b0;
                        {r_q1_busy[i], r_v1[i]} <= w_wake1[i];
                        {r_q2_busy[i], r_v2[i]} <= w_wake2[i];
                        if (r_valid[i] && commit_valid && commit_rob_id == r_rob[i])
                            r_committed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_size   <= '0;
            r_cur_type   <= '0;
            r_cur_rob    <= '0;
            r_squash     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_rob_id <= '0;
            r_out_val    <= '0;
        end else if (rdy_in) begin
            r_out_valid <= w_report;
            if (w_report) begin
                r_out_rob_id <= r_cur_rob;
                r_out_val    <= r_mem_we ? 32'h0 : f_ext(mem_rdata, r_cur_type);
            end
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= w_head_addr;
                r_mem_wdata <= r_v2[r_head];
                r_mem_we    <= w_head_store;
                r_mem_size  <= r_type[r_head][1:0];
                r_cur_type  <= r_type[r_head];
                r_cur_rob   <= r_rob[r_head];
                r_squash    <= 1'b0;
            end else if (w_finish) begin
                r_mem_req <= 1'b0;
            end
            if (r_state == S_BUSY && clear_flag)
                r_squash <= 1'b1;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_size   = r_mem_size;
    assign out_valid  = r_out_valid;
    assign out_rob_id = r_out_rob_id;
    assign out_val    = r_out_val;

endmodule

// File: tb/tb_lsb_queue.sv
// Bench for lsb_queue: directed scenarios, then randomized traffic checked against
// a program-order request/result scoreboard.
module tb_lsb_queue;
    localparam int DEPTH_BIT = 4;
    localparam int ROB_BIT   = 5;
    localparam int CDB_NUM   = 2;

    logic                       clk_in = 1'b0;
    logic                       rst_in, rdy_in, clear_flag, ins_valid;
    logic [3:0]                 ins_type;
    logic [ROB_BIT-1:0]         ins_rob_id, ins_q1, ins_q2, commit_rob_id;
    logic [31:0]                ins_v1, ins_v2, ins_imm, mem_rdata;
    logic                       ins_q1_busy, ins_q2_busy, commit_valid, mem_done;
    logic [CDB_NUM-1:0]         cdb_valid;
    logic [CDB_NUM*ROB_BIT-1:0] cdb_rob_id;
    logic [CDB_NUM*32-1:0]      cdb_val;
    logic                       lsb_full, mem_req, mem_we, out_valid;
    logic [31:0]                mem_addr, mem_wdata, out_val;
    logic [1:0]                 mem_size;
    logic [ROB_BIT-1:0]         out_rob_id;

    always #5 clk_in = ~clk_in;

    lsb_queue #(.DEPTH_BIT(DEPTH_BIT), .ROB_BIT(ROB_BIT), .CDB_NUM(CDB_NUM), .IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .ins_valid(ins_valid), .ins_type(ins_type), .ins_rob_id(ins_rob_id),
        .ins_v1(ins_v1), .ins_v2(ins_v2), .ins_q1_busy(ins_q1_busy), .ins_q2_busy(ins_q2_busy),
        .ins_q1(ins_q1), .ins_q2(ins_q2), .ins_imm(ins_imm), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rob_id(out_rob_id), .out_val(out_val)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference rules: byte/half sign or zero extension by opcode, access size by opcode.
    function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [3:0] t);
        byte     b;
        shortint h;
        b = d[7:0];
        h = d[15:0];
        case (t)
            4'd0:    return int'(b);
            4'd1:    return int'(h);
            4'd4:    return 32'(d[7:0]);
            4'd5:    return 32'(d[15:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic [1:0] ref_size(input logic [3:0] t);
        if (t == 4'd2 || t == 4'd10) return 2'd2;
        if (t == 4'd1 || t == 4'd5 || t == 4'd9) return 2'd1;
        return 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; clear_flag = 1'b0; ins_valid = 1'b0; ins_type = '0; ins_rob_id = '0;
        ins_v1 = '0; ins_v2 = '0; ins_imm = '0; ins_q1_busy = 1'b0; ins_q2_busy = 1'b0;
        ins_q1 = '0; ins_q2 = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_val = '0;
        commit_valid = 1'b0; commit_rob_id = '0; mem_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic set_ins(input logic [3:0] t, input logic [4:0] rob, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] imm);
        ins_valid = 1'b1; ins_type = t; ins_rob_id = rob; ins_v1 = v1; ins_v2 = v2; ins_imm = imm;
        ins_q1_busy = 1'b0; ins_q2_busy = 1'b0; ins_q1 = '0; ins_q2 = '0;
    endtask

    task automatic wait_req(input string tag, input int lim);
        int n = 0;
        while (!mem_req && n < lim) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(mem_req), 64'd1);
    endtask

    task automatic mem_reply(input logic [31:0] d);
        mem_done = 1'b1;
        mem_rdata = d;
        tick();
        mem_done = 1'b0;
        $display("txn mem_done rdata=%h -> out_valid=%0d rob=%0d val=%h", d, out_valid, out_rob_id, out_val);
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; logic [1:0] size;
                     logic [3:0] t; logic [4:0] rob; } req_t;
    typedef struct { logic [4:0] rob; logic [31:0] val; } res_t;
    typedef struct { logic [4:0] id; logic [31:0] val; int dly; } ev_t;

    logic [3:0]  typ_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};
    logic [3:0]  ld_t    [3] = '{4'd2, 4'd0, 4'd4};
    logic [1:0]  ld_sz   [3] = '{2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp  [3] = '{32'h8000_00F0, 32'hFFFF_FFF0, 32'h0000_00F0};

    req_t exp_req[$];
    res_t exp_res[$];
    ev_t  bcq[$];
    ev_t  cmq[$];
    req_t cur, nr;
    res_t rr;
    int   n_prog, nd, n_issued, cyc, lat, port, idx, busy;
    bit   mem_act;
    logic [3:0]  t;
    logic [31:0] v1r, v2r, imm;

    initial begin
        idle_inputs();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        tick();
        check_eq("rst_ctl", {mem_req, mem_we, mem_size, out_valid, lsb_full, out_rob_id}, 64'd0);
        check_eq("rst_data", {mem_addr, out_val}, 64'd0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'd0);

        for (int i = 0; i < 3; i++) begin
            set_ins(ld_t[i], 5'd1, 32'h100, 32'h0, 32'h4);
            tick();
            ins_valid = 1'b0;
            wait_req("ld_req", 10);
            check_eq("ld_addr", {mem_we, mem_size, mem_addr}, {1'b0, ld_sz[i], 32'h104});
            mem_reply(32'h8000_00F0);
            check_eq("ld_out", {out_valid, out_rob_id, out_val}, {1'b1, 5'd1, ld_exp[i]});
            tick();
            check_eq("ld_pulse", 64'(out_valid), 64'd0);
        end

        set_ins(4'd10, 5'd3, 32'h40, 32'hDEAD_BEEF, 32'h0);
        tick();
        ins_valid = 1'b0;
        repeat (5) tick();
        check_eq("st_wait", 64'(mem_req), 64'd0);
        commit_valid = 1'b1; commit_rob_id = 5'd3;
        tick();
        commit_valid = 1'b0;
        wait_req("st_req", 5);
        check_eq("st_data", {mem_we, mem_size, mem_wdata}, {1'b1, 2'd2, 32'hDEAD_BEEF});
        mem_reply(32'h1357_9BDF);
        check_eq("st_out", {out_valid, out_rob_id, out_val}, {1'b1, 5'd3, 32'h0});
        tick();

        set_ins(4'd0, 5'd4, 32'h0003_0000, 32'h0, 32'h0);
        tick();
        set_ins(4'd2, 5'd5, 32'h100, 32'h0, 32'h0);
        tick();
        ins_valid = 1'b0;
        repeat (4) tick();
        check_eq("io_wait", 64'(mem_req), 64'd0);
        commit_valid = 1'b1; commit_rob_id = 5'd4;
        tick();
        commit_valid = 1'b0;
        wait_req("io_req", 5);
        check_eq("io_addr", 64'(mem_addr), 64'h0003_0000);
        mem_reply(32'h0000_007F);
        check_eq("io_out", {out_valid, out_rob_id, out_val}, {1'b1, 5'd4, 32'h7F});
        wait_req("io_next", 5);
        check_eq("io_next_addr", 64'(mem_addr), 64'h100);
        mem_reply(32'h0000_1234);
        check_eq("io_next_out", {out_valid, out_rob_id, out_val}, {1'b1, 5'd5, 32'h1234});
        tick();

        set_ins(4'd2, 5'd6, 32'h0BAD, 32'h0, 32'h10);
        ins_q1_busy = 1'b1; ins_q1 = 5'd7;
        cdb_valid = 2'b10; cdb_rob_id = {5'd7, 5'd0}; cdb_val = {32'h200, 32'h0};
        tick();
        idle_inputs();
        wait_req("byp_req", 5);
        check_eq("byp_addr", 64'(mem_addr), 64'h210);
        mem_reply(32'h0);
        tick();

        set_ins(4'd2, 5'd8, 32'h0BAD, 32'h0, 32'h10);
        ins_q1_busy = 1'b1; ins_q1 = 5'd9;
        cdb_valid = 2'b11; cdb_rob_id = {5'd9, 5'd9}; cdb_val = {32'h400, 32'h300};
        tick();
        idle_inputs();
        wait_req("prio_req", 5);
        check_eq("prio_addr", 64'(mem_addr), 64'h310);
        mem_reply(32'h0);
        tick();

        set_ins(4'd2, 5'd10, 32'h700, 32'h0, 32'h0);
        tick();
        ins_valid = 1'b0;
        rdy_in = 1'b0;
        repeat (3) tick();
        check_eq("rdy_freeze", 64'(mem_req), 64'd0);
        rdy_in = 1'b1;
        tick();
        check_eq("rdy_resume", {mem_req, mem_addr}, {1'b1, 32'h700});
        mem_reply(32'h0);
        tick();

        for (int i = 0; i < 15; i++) begin
            if (i == 14) check_eq("not_full_14", 64'(lsb_full), 64'd0);
            set_ins(4'd10, 5'(i), 32'(i * 4), 32'h0, 32'h0);
            tick();
        end
        ins_valid = 1'b0;
        check_eq("full_15", 64'(lsb_full), 64'd1);
        clear_flag = 1'b1;
        tick();
        clear_flag = 1'b0;
        check_eq("flush_count", 64'(lsb_full), 64'd0);
        commit_valid = 1'b1; commit_rob_id = 5'd0;
        tick();
        commit_valid = 1'b0;
        repeat (3) tick();
        check_eq("flush_empty", 64'(mem_req), 64'd0);

        set_ins(4'd2, 5'd20, 32'h500, 32'h0, 32'h0);
        tick();
        ins_valid = 1'b0;
        wait_req("drain_req", 5);
        clear_flag = 1'b1;
        tick();
        clear_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_hold", {mem_req, out_valid}, 64'b10);
            tick();
        end
        mem_reply(32'hAAAA_5555);
        check_eq("drain_done", {mem_req, out_valid}, 64'b00);
        tick();
        check_eq("drain_quiet", 64'(out_valid), 64'd0);

        set_ins(4'd2, 5'd21, 32'h600, 32'h0, 32'h0);
        tick();
        ins_valid = 1'b0;
        wait_req("arst_req", 5);
        #2 rst_in = 1'b1;
        #1 check_eq("arst_outs", {mem_req, out_valid, lsb_full, mem_we, mem_addr}, 64'd0);
        #1 rst_in = 1'b0;
        tick();
        check_eq("arst_after", {mem_req, out_valid, out_val}, 64'd0);

        // Randomized traffic: program-order request and result scoreboards.
        idle_inputs();
        n_prog = 80; nd = 0; n_issued = 0; cyc = 0; mem_act = 1'b0; lat = 0;
        while ((nd < n_prog || exp_req.size() > 0 || exp_res.size() > 0 || mem_act) && cyc < 20000) begin
            if (out_valid) begin
                if (exp_res.size() == 0) begin
                    check_eq("rnd_spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    rr = exp_res.pop_front();
                    check_eq("rnd_out", {out_rob_id, out_val}, {rr.rob, rr.val});
                    $display("txn result rob=%0d val=%h", out_rob_id, out_val);
                end
            end
            mem_done = 1'b0;
            if (mem_req && !mem_act) begin
                if (exp_req.size() == 0) begin
                    check_eq("rnd_spurious_req", 64'(mem_req), 64'd0);
                end else begin
                    cur = exp_req.pop_front();
                    n_issued++;
                    check_eq("rnd_req", {mem_we, mem_size, mem_addr}, {cur.we, cur.size, cur.addr});
                    if (cur.we) check_eq("rnd_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    mem_act = 1'b1;
                    lat = $urandom_range(0, 3);
                end
            end
            check_eq("rnd_full", 64'(lsb_full), 64'((nd - n_issued) >= 15));
            if (mem_act) begin
                if (lat == 0) begin
                    mem_done = 1'b1;
                    mem_rdata = $urandom;
                    exp_res.push_back('{cur.rob, cur.we ? 32'h0 : ref_ext(mem_rdata, cur.t)});
                    mem_act = 1'b0;
                end else begin
                    lat--;
                end
            end

            ins_valid = 1'b0;
            if (nd < n_prog && !lsb_full && $urandom_range(0, 3) != 0) begin
                t    = typ_tab[$urandom_range(0, 7)];
                v1r  = ($urandom_range(0, 7) == 0) ? 32'h0003_0000 + $urandom_range(0, 255)
                                                    : 32'($urandom_range(0, 16'hFFFF));
                v2r  = $urandom;
                imm  = 32'($urandom_range(0, 255));
                busy = $urandom_range(0, 2);
                set_ins(t, 5'(nd % 16), (busy == 1) ? $urandom : v1r, (busy == 2) ? $urandom : v2r, imm);
                ins_q1_busy = (busy == 1);
                ins_q2_busy = (busy == 2);
                ins_q1 = (busy == 1) ? 5'(16 + nd % 16) : 5'($urandom_range(0, 31));
                ins_q2 = (busy == 2) ? 5'(16 + nd % 16) : 5'($urandom_range(0, 31));
                if (busy != 0)
                    bcq.push_back('{5'(16 + nd % 16), (busy == 1) ? v1r : v2r, $urandom_range(0, 3)});
                nr = '{v1r + imm, v2r, (t >= 4'd8), ref_size(t), t, 5'(nd % 16)};
                if (nr.we || nr.addr >= 32'h0003_0000)
                    cmq.push_back('{5'(nd % 16), 32'h0, $urandom_range(0, 4)});
                exp_req.push_back(nr);
                nd++;
            end

            cdb_valid = '0; cdb_rob_id = '0; cdb_val = '0;
            port = $urandom_range(0, 1);
            idx = -1;
            foreach (bcq[j]) if (idx < 0 && bcq[j].dly <= 0) idx = j;
            if (idx >= 0) begin
                cdb_valid[port] = 1'b1;
                cdb_rob_id[port*ROB_BIT +: ROB_BIT] = bcq[idx].id;
                cdb_val[port*32 +: 32] = bcq[idx].val;
                bcq.delete(idx);
            end
            if ($urandom_range(0, 3) == 0) begin
                cdb_valid[1-port] = 1'b1;
                cdb_rob_id[(1-port)*ROB_BIT +: ROB_BIT] = 5'($urandom_range(0, 15));
                cdb_val[(1-port)*32 +: 32] = $urandom;
            end
            foreach (bcq[j]) if (bcq[j].dly > 0) bcq[j].dly--;

            commit_valid = 1'b0;
            idx = -1;
            foreach (cmq[j]) if (idx < 0 && cmq[j].dly <= 0) idx = j;
            if (idx >= 0) begin
                commit_valid = 1'b1;
                commit_rob_id = cmq[idx].id;
                cmq.delete(idx);
            end
            foreach (cmq[j]) if (cmq[j].dly > 0) cmq[j].dly--;

            tick();
            cyc++;
        end
        idle_inputs();
        check_eq("rnd_dispatched", 64'(nd), 64'(n_prog));
        check_eq("rnd_leftover", 64'(exp_req.size() + exp_res.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
